// File: rtl/mem_pkg.sv
// Shared types and parameter defaults for the fetch/data memory arbiter.
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int MEM_LAT_DEFAULT    = 2;
  localparam int STARVE_MAX_DEFAULT = 4;

  // Fetches always read a full word.
  localparam logic [3:0] FETCH_BE = 4'b1111;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory port.
interface mem_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    input  m_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_be, m_addr, m_wdata
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_be, d_addr, d_wdata,
    output m_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_be, m_addr, m_wdata
  );

endinterface

// File: rtl/mem_arb_starve.sv
// Saturating count of consecutive fetch losses; o_force_if flips priority to fetch.
module mem_arb_starve
  import mem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_force_if
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_force_if = (r_cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single fixed-latency memory, one transaction in flight.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_LAT    = MEM_LAT_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic          busy
);

  arb_state_t r_state;
  owner_t     r_owner;
  logic [3:0] r_lat_cnt;

  logic w_idle;
  logic w_force_if;
  logic w_grant_d;
  logic w_grant_if;
  logic w_last;

  // Outputs are gated by reset so nothing is granted or returned while it is held.
  assign w_idle     = reset && (r_state == IDLE);
  assign w_grant_d  = w_idle && bus.d_req && !(bus.if_req && w_force_if);
  assign w_grant_if = w_idle && bus.if_req && !w_grant_d;
  assign w_last     = reset && (r_state == WAIT) && (r_lat_cnt == 4'd1);

  mem_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .i_inc      (w_idle && bus.if_req && w_grant_d),
    .i_clr      (w_idle && (!bus.if_req || w_grant_if)),
    .o_force_if (w_force_if)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
      r_owner   <= OWN_IF;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d || w_grant_if) begin
            r_state   <= WAIT;
            r_lat_cnt <= 4'(MEM_LAT);
            r_owner   <= w_grant_d ? OWN_D : OWN_IF;
          end
        end
        WAIT: begin
          r_lat_cnt <= r_lat_cnt - 4'd1;
          if (r_lat_cnt == 4'd1) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    bus.m_req   = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_be    = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    if (w_grant_d) begin
      bus.m_req   = 1'b1;
      bus.m_we    = bus.d_we;
      bus.m_be    = bus.d_be;
      bus.m_addr  = bus.d_addr;
      bus.m_wdata = bus.d_wdata;
    end else if (w_grant_if) begin
      bus.m_req   = 1'b1;
      bus.m_be    = FETCH_BE;
      bus.m_addr  = bus.if_addr;
    end
  end

  assign bus.if_gnt    = w_grant_if;
  assign bus.d_gnt     = w_grant_d;
  assign bus.if_rvalid = w_last && (r_owner == OWN_IF);
  assign bus.d_rvalid  = w_last && (r_owner == OWN_D);
  assign bus.if_rdata  = bus.if_rvalid ? bus.m_rdata : '0;
  assign bus.d_rdata   = bus.d_rvalid  ? bus.m_rdata : '0;
  assign busy          = reset && (r_state == WAIT);

endmodule
